mult_div_ctrl: RTL and testbench
================================

// Module: mult_div_ctrl
// PURPOSE
//  Sequencer for the shared iterative multiply/divide resource behind HI/LO.
//  Accepts a one-cycle start from Unidade_Controle (Mult_s/Div_s states) and runs a 32-step
//  radix-2 signed multiply or restoring signed divide on rs/rt, then loads HI/LO.
//  Holds busy while running so the control unit stalls in WriteHILO_s until done.
// PARAMETERS
//  WIDTH   32   operand width; iteration count = WIDTH; HI/LO are WIDTH bits each
//  CNT_W   6    iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clock     in   1      system clock, rising edge
//  RESET_in  in   1      asynchronous, active-low reset
//  start     in   1      request; sampled only in IDLE
//  op        in   1      0 = mult, 1 = div; sampled with start
//  a         in   WIDTH  rs operand (multiplicand / dividend), sampled with start
//  b         in   WIDTH  rt operand (multiplier / divisor), sampled with start
//  busy      out  1      1 in every state except IDLE
//  done      out  1      1 for exactly the one cycle spent in DONE
//  hi        out  WIDTH  HI register
//  lo        out  WIDTH  LO register
//  div_zero  out  1      divide-by-zero exception pulse (see CONFIGURATION)
// BEHAVIOUR
//  Reset (RESET_in=0, any time, incl. mid-operation): state=IDLE, counter=0, hi=0, lo=0,
//   busy=0, done=0, div_zero=0, operand/work registers cleared. Operation in flight is lost.
//  FSM: IDLE -> LOAD -> RUN -> FIX -> DONE -> IDLE.
//   IDLE: start=1 -> capture op,a,b; go LOAD. start=0 -> stay.
//   LOAD: take magnitudes |a|,|b|, record result signs; counter=WIDTH-1; go RUN.
//   RUN : one iteration per cycle; counter==0 on an iteration -> go FIX, else counter-1.
//   FIX : negate quotient/product/remainder per recorded signs.
//   DONE: hi/lo loaded on the edge entering DONE; done=1; next edge -> IDLE.
//  Latency: start sampled at edge E0 -> done high in cycle after edge E(WIDTH+2) (34 for 32).
//  start while busy (any non-IDLE state, incl. DONE) is ignored; no queuing.
//  hi/lo change only on the edge entering DONE; they hold their values otherwise.
//  Mult: signed a*b, 2*WIDTH product; hi=product[2W-1:W], lo=product[W-1:0].
//  Div : signed, truncate toward zero; lo=quotient, hi=remainder with sign of dividend.
//   MIN/-1 (0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0 (no trap, wraps).
//  Arithmetic: magnitudes in WIDTH+1 bits so |MIN| is representable; final results truncated.
// CONFIGURATION
//  DIVZERO_EXC_EN defined: op=1 with b==0 detected in LOAD -> skip RUN/FIX/DONE, go IDLE;
//   div_zero=1 for that one cycle back in IDLE; done stays 0; hi/lo unchanged.
//  DIVZERO_EXC_EN undefined: div_zero tied 0; b==0 runs normally with full latency:
//   hi=a, lo=(a[WIDTH-1] ? 1 : 0xFFFFFFFF); done pulses as usual.
// TESTING
//  mult a=7, b=0xFFFFFFFD -> done at cycle 34, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy 1 cycles 1-33.
//  mult a=b=0x80000000 -> hi=0x40000000, lo=0x00000000.
//  div a=0xFFFFFFF9(-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; a=0x80000000,b=0xFFFFFFFF -> lo=0x80000000, hi=0.
//  div a=5, b=0: with DIVZERO_EXC_EN -> div_zero pulse 2 cycles after start, no done, hi/lo kept;
//   without -> done at 34, hi=5, lo=0xFFFFFFFF.
//  start=1 held during RUN with different a/b/op -> ignored, result of first op only, one done.
//  RESET_in low mid-RUN after prior result 0x1234/0x5678 -> hi=lo=0, busy=0 immediately; next op ok.

Source files
------------

// File: rtl/mult_div_ctrl.sv
// Sequencer for the shared iterative signed multiply / restoring divide unit feeding HI/LO.
// Define DIVZERO_EXC_EN to abort divides by zero with a div_zero pulse instead of running them.
module mult_div_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             RESET_in,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [WIDTH:0]   opb_q, opb_d;
  logic             negRes_q, negRes_d, negRem_q, negRem_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             divZero_q, divZero_d;

  // One extra bit keeps |MIN| representable as a positive magnitude.
  logic [WIDTH:0]     magA, magB, multSum, divShift, divDiff;
  logic               divFits;
  logic [2*WIDTH-1:0] product, productNeg;
  logic               unusedBits;

  assign magA       = a_q[WIDTH-1] ? -{a_q[WIDTH-1], a_q} : {a_q[WIDTH-1], a_q};
  assign magB       = b_q[WIDTH-1] ? -{b_q[WIDTH-1], b_q} : {b_q[WIDTH-1], b_q};
  assign multSum    = {1'b0, acc_q} + (mq_q[0] ? opb_q : '0);
  assign divShift   = {acc_q, mq_q[WIDTH-1]};
  assign divDiff    = divShift - opb_q;
  assign divFits    = (divShift >= opb_q);
  assign product    = {acc_q, mq_q};
  assign productNeg = -product;
  assign unusedBits = divDiff[WIDTH];

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

`ifdef DIVZERO_EXC_EN
  assign div_zero = divZero_q;
`else
  assign div_zero = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    opb_d     = opb_q;
    negRes_d  = negRes_q;
    negRem_d  = negRem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    divZero_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          state_d = LOAD;
        end
      end
      LOAD: begin
        negRes_d = a_q[WIDTH-1] ^ b_q[WIDTH-1];
        negRem_d = a_q[WIDTH-1];
        acc_d    = '0;
        cnt_d    = CNT_W'(WIDTH - 1);
        if (op_q) begin
          mq_d  = magA[WIDTH-1:0];
          opb_d = magB;
        end else begin
          mq_d  = magB[WIDTH-1:0];
          opb_d = magA;
        end
        state_d = RUN;
`ifdef DIVZERO_EXC_EN
        if (op_q && (b_q == '0)) begin
          state_d   = IDLE;
          divZero_d = 1'b1;
        end
`endif
      end
      RUN: begin
        if (op_q) begin
          acc_d = divFits ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0];
          mq_d  = {mq_q[WIDTH-2:0], divFits};
        end else begin
          acc_d = multSum[WIDTH:1];
          mq_d  = {multSum[0], mq_q[WIDTH-1:1]};
        end
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      FIX: begin
        if (op_q) begin
          lo_d = negRes_q ? -mq_q  : mq_q;
          hi_d = negRem_q ? -acc_q : acc_q;
        end else begin
          {hi_d, lo_d} = negRes_q ? productNeg : product;
        end
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge RESET_in) begin
    if (!RESET_in) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      opb_q     <= '0;
      negRes_q  <= 1'b0;
      negRem_q  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      divZero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      opb_q     <= opb_d;
      negRes_q  <= negRes_d;
      negRem_q  <= negRem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      divZero_q <= divZero_d;
    end
  end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed bench for mult_div_ctrl: signed mult/div vectors, latency, busy/done framing,
// ignored restarts, async reset mid-run and divide-by-zero in either DIVZERO_EXC_EN build.
module tb_mult_div_ctrl;

  logic        clock;
  logic        RESET_in;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;

  int checks = 0;
  int errors = 0;
  int dzSeen = 0;

  mult_div_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clock(clock), .RESET_in(RESET_in), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) if (div_zero) dzSeen++;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Presents one start pulse; returns at the falling edge just after the sampling edge.
  task automatic applyStimulus(input logic opIn, input logic [31:0] aIn, input logic [31:0] bIn);
    @(negedge clock);
    start = 1'b1;
    op    = opIn;
    a     = aIn;
    b     = bIn;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic runOp(input string tag, input logic opIn, input logic [31:0] aIn, input logic [31:0] bIn,
                       input logic [31:0] expHi, input logic [31:0] expLo);
    logic [31:0] prevHi, prevLo;
    int lat;
    logic busyOk, holdOk;
    prevHi = hi;
    prevLo = lo;
    applyStimulus(opIn, aIn, bIn);
    lat    = -1;
    busyOk = 1'b1;
    holdOk = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      if (!busy) busyOk = 1'b0;
      if (hi !== prevHi || lo !== prevLo) holdOk = 1'b0;
      @(negedge clock);
    end
    checkOutput($sformatf("%s latency", tag), 64'(lat), 64'd34);
    checkOutput($sformatf("%s hi", tag), {32'd0, hi}, {32'd0, expHi});
    checkOutput($sformatf("%s lo", tag), {32'd0, lo}, {32'd0, expLo});
    checkOutput($sformatf("%s busyRun", tag), {63'd0, busyOk}, 64'd1);
    checkOutput($sformatf("%s hiloHold", tag), {63'd0, holdOk}, 64'd1);
    checkOutput($sformatf("%s busyInDone", tag), {63'd0, busy}, 64'd1);
    @(negedge clock);
    checkOutput($sformatf("%s doneDrop", tag), {62'd0, done, busy}, 64'd0);
  endtask

  initial begin
    int dones;
    logic [31:0] capHi, capLo;
    RESET_in = 1'b0;
    start    = 1'b0;
    op       = 1'b0;
    a        = '0;
    b        = '0;
    repeat (3) @(negedge clock);
    checkOutput("reset hi", {32'd0, hi}, 64'd0);
    checkOutput("reset lo", {32'd0, lo}, 64'd0);
    checkOutput("reset flags", {61'd0, busy, done, div_zero}, 64'd0);
    RESET_in = 1'b1;
    @(negedge clock);
    checkOutput("idle flags", {61'd0, busy, done, div_zero}, 64'd0);

    runOp("mul7xm3",   1'b0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
    runOp("mulMinMin", 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    runOp("mulBig",    1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000);
    runOp("mulM1M1",   1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001);
    runOp("divM7by2",  1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
    runOp("divMinM1",  1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    runOp("div100by7", 1'b1, 32'd100,      32'd7,        32'd2,        32'd14);
    runOp("div7byM2",  1'b1, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD);

    // Start held through RUN with a different request must not disturb or queue.
    @(negedge clock);
    start = 1'b1; op = 1'b0; a = 32'd7; b = 32'hFFFFFFFD;
    @(negedge clock);
    op = 1'b1; a = 32'd100; b = 32'd3;
    repeat (20) @(negedge clock);
    start = 1'b0;
    dones = 0;
    capHi = '0;
    capLo = '0;
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        dones++;
        capHi = hi;
        capLo = lo;
      end
      @(negedge clock);
    end
    checkOutput("heldStart dones", 64'(dones), 64'd1);
    checkOutput("heldStart hi", {32'd0, capHi}, 64'hFFFFFFFF);
    checkOutput("heldStart lo", {32'd0, capLo}, 64'hFFFFFFEB);

    // Async reset in the middle of RUN wipes results immediately.
    runOp("divSetup", 1'b1, 32'h0ACF1234, 32'h00002000, 32'h00001234, 32'h00005678);
    applyStimulus(1'b0, 32'd9, 32'd9);
    repeat (10) @(negedge clock);
    RESET_in = 1'b0;
    #1;
    checkOutput("midReset hi", {32'd0, hi}, 64'd0);
    checkOutput("midReset lo", {32'd0, lo}, 64'd0);
    checkOutput("midReset flags", {62'd0, busy, done}, 64'd0);
    @(negedge clock);
    RESET_in = 1'b1;
    runOp("afterReset", 1'b0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);

`ifdef DIVZERO_EXC_EN
    applyStimulus(1'b1, 32'd5, 32'd0);
    checkOutput("dz loadCycle", {62'd0, div_zero, busy}, 64'd1);
    @(negedge clock);
    checkOutput("dz pulse", {61'd0, div_zero, busy, done}, 64'd4);
    checkOutput("dz hiKept", {32'd0, hi}, 64'hFFFFFFFF);
    checkOutput("dz loKept", {32'd0, lo}, 64'hFFFFFFEB);
    @(negedge clock);
    checkOutput("dz pulseEnd", {63'd0, div_zero}, 64'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dones++;
      @(negedge clock);
    end
    checkOutput("dz noDone", 64'(dones), 64'd0);
    checkOutput("dz pulseCount", 64'(dzSeen), 64'd1);
`else
    runOp("divBy0", 1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
    runOp("divM5By0", 1'b1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'd1);
    checkOutput("dz neverPulses", 64'(dzSeen), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
